muldiv_sched: RTL and testbench

- Scheduler for the shared iterative multiply/divide unit.
- Accepts one M-extension op from execute and sequences the unit through start/done.
- Keeps a one-entry scoreboard of the pending destination register and stalls decode on RAW/WAW hazards against it.
- Arbitrates the single register-file write port between the normal mem1 writeback and the muldiv result.

---
 rtl/muldiv_sched_if.sv | 15 +
 rtl/muldiv_sched.sv | 140 ++++++++++++++
 tb/tb_muldiv_sched.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sched_if.sv
// rtl/muldiv_sched_if.sv - handshake between the scheduler and the iterative multiply/divide unit
interface muldiv_sched_if #(
  parameter int XLEN = 32
);
  logic            md_start;
  logic [2:0]      md_op;
  logic [XLEN-1:0] md_a;
  logic [XLEN-1:0] md_b;
  logic            md_busy;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  modport master (output md_start, md_op, md_a, md_b, input md_busy, md_done, md_result);
  modport slave  (input md_start, md_op, md_a, md_b, output md_busy, md_done, md_result);
endinterface

// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - muldiv op sequencing, one-entry destination scoreboard and write-port arbitration
module muldiv_sched #(
  parameter int XLEN     = 32,
  parameter int HOLD_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_md_valid,
  input  logic [2:0]           ex_md_op,
  input  logic [4:0]           ex_md_rd,
  input  logic [XLEN-1:0]      ex_md_a,
  input  logic [XLEN-1:0]      ex_md_b,
  output logic                 md_ex_stall,
  muldiv_sched_if.master       md,
  input  logic [4:0]           de_rs1,
  input  logic [4:0]           de_rs2,
  input  logic [4:0]           de_rd,
  input  logic                 de_wb,
  output logic                 md_de_stall,
  input  logic                 mem1_wb_valid,
  input  logic [4:0]           mem1_wb_reg,
  input  logic [XLEN-1:0]      mem1_wb_data,
  output logic                 wb_stall,
  output logic                 wb_valid,
  output logic [4:0]           wb_reg,
  output logic [XLEN-1:0]      wb_data
);
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  localparam logic [3:0] HOLD_LIMIT = 4'(HOLD_MAX);

  state_t          state, state_nxt;
  logic            pending, pending_nxt;
  logic [4:0]      pend_rd, pend_rd_nxt;
  logic [XLEN-1:0] hold_data, hold_data_nxt;
  logic [3:0]      hold_cnt, hold_cnt_nxt;
  logic            accept;
  logic            md_wr;
  logic [XLEN-1:0] md_wr_data;
  logic [4:0]      hazard_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= 1'b0;
      pend_rd   <= 5'd0;
      hold_data <= '0;
      hold_cnt  <= 4'd0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      pend_rd   <= pend_rd_nxt;
      hold_data <= hold_data_nxt;
      hold_cnt  <= hold_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending;
    pend_rd_nxt   = pend_rd;
    hold_data_nxt = hold_data;
    hold_cnt_nxt  = hold_cnt;
    accept        = 1'b0;
    md_wr         = 1'b0;
    md_wr_data    = hold_data;
    wb_stall      = 1'b0;
    md_ex_stall   = 1'b0;
    md.md_start   = 1'b0;
    md.md_op      = 3'd0;
    md.md_a       = '0;
    md.md_b       = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          md_ex_stall = ex_md_valid & md.md_busy;
          if (ex_md_valid && !md.md_busy) begin
            accept      = 1'b1;
            md.md_start = 1'b1;
            md.md_op    = ex_md_op;
            md.md_a     = ex_md_a;
            md.md_b     = ex_md_b;
            pend_rd_nxt = ex_md_rd;
            pending_nxt = (ex_md_rd != 5'd0);
            state_nxt   = BUSY;
          end
        end
        BUSY: begin
          md_ex_stall = ex_md_valid;
          if (md.md_done) begin
            // A result for x0 is dropped outright, so it never competes for the port.
            if (pend_rd == 5'd0 || !mem1_wb_valid) begin
              md_wr       = (pend_rd != 5'd0);
              md_wr_data  = md.md_result;
              pending_nxt = 1'b0;
              state_nxt   = IDLE;
            end else begin
              hold_data_nxt = md.md_result;
              hold_cnt_nxt  = 4'd1;
              state_nxt     = HOLD;
            end
          end
        end
        HOLD: begin
          md_ex_stall = ex_md_valid;
          if (!mem1_wb_valid || hold_cnt == HOLD_LIMIT) begin
            md_wr       = 1'b1;
            wb_stall    = mem1_wb_valid;
            pending_nxt = 1'b0;
            state_nxt   = IDLE;
          end else begin
            hold_cnt_nxt = hold_cnt + 4'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign hazard_rd   = accept ? ex_md_rd : (pending ? pend_rd : 5'd0);
  assign md_de_stall = !reset && (hazard_rd != 5'd0) &&
                       (de_rs1 == hazard_rd || de_rs2 == hazard_rd || (de_wb && de_rd == hazard_rd));

  always_comb begin
    wb_valid = 1'b0;
    wb_reg   = 5'd0;
    wb_data  = '0;
    if (!reset) begin
      if (md_wr) begin
        wb_valid = 1'b1;
        wb_reg   = pend_rd;
        wb_data  = md_wr_data;
      end else begin
        wb_valid = mem1_wb_valid & !wb_stall;
        wb_reg   = mem1_wb_reg;
        wb_data  = mem1_wb_data;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_sched.sv
// tb/tb_muldiv_sched.sv - directed vector table plus randomized run against a reference model
module tb_muldiv_sched;
  localparam int XLEN     = 32;
  localparam int HOLD_MAX = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            ex_md_valid;
  logic [2:0]      ex_md_op;
  logic [4:0]      ex_md_rd;
  logic [XLEN-1:0] ex_md_a, ex_md_b;
  logic            md_ex_stall;
  logic [4:0]      de_rs1, de_rs2, de_rd;
  logic            de_wb;
  logic            md_de_stall;
  logic            mem1_wb_valid;
  logic [4:0]      mem1_wb_reg;
  logic [XLEN-1:0] mem1_wb_data;
  logic            wb_stall, wb_valid;
  logic [4:0]      wb_reg;
  logic [XLEN-1:0] wb_data;

  muldiv_sched_if #(.XLEN(XLEN)) mif ();

  muldiv_sched #(.XLEN(XLEN), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .reset(reset),
    .ex_md_valid(ex_md_valid), .ex_md_op(ex_md_op), .ex_md_rd(ex_md_rd),
    .ex_md_a(ex_md_a), .ex_md_b(ex_md_b), .md_ex_stall(md_ex_stall),
    .md(mif.master),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rd(de_rd), .de_wb(de_wb), .md_de_stall(md_de_stall),
    .mem1_wb_valid(mem1_wb_valid), .mem1_wb_reg(mem1_wb_reg), .mem1_wb_data(mem1_wb_data),
    .wb_stall(wb_stall), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(string nm, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  typedef struct {
    string name;
    int rst, exv, exop, exrd, busy, done, res, memv, memreg, memdata, rs1, rs2, derd, dewb;
    int start, exst, dest, wbst, wbv, wbreg, wbdata;
  } vec_t;

  vec_t tbl[32];

  task automatic check_outs(string nm, int start, int exst, int dest, int wbst, int wbv, int wbreg, int wbdata);
    chk({nm, ".md_start"}, int'(mif.md_start), start);
    chk({nm, ".md_ex_stall"}, int'(md_ex_stall), exst);
    chk({nm, ".md_de_stall"}, int'(md_de_stall), dest);
    chk({nm, ".wb_stall"}, int'(wb_stall), wbst);
    chk({nm, ".wb_valid"}, int'(wb_valid), wbv);
    chk({nm, ".wb_reg"}, int'(wb_reg), wbreg);
    chk({nm, ".wb_data"}, int'(wb_data), wbdata);
  endtask

  // reference model: at most one op in flight, optionally parked waiting for the write port
  bit          op_run, held;
  int          pend, age, run_left;
  logic [31:0] held_val;
  bit          hold_ex;

  initial begin
    tbl[0]  = '{"reset",          1,1,0,5,  0,0,0,     1,9,'h99, 5,0,0,0, 0,0,0,0,0,0,0};
    tbl[1]  = '{"mul_acc",        0,1,0,5,  0,0,0,     0,0,0,    5,0,0,0, 1,0,1,0,0,0,0};
    tbl[2]  = '{"mul_busy1",      0,0,0,0,  1,0,0,     0,0,0,    5,0,0,0, 0,0,1,0,0,0,0};
    tbl[3]  = '{"mul_busy2",      0,0,0,0,  1,0,0,     0,0,0,    5,0,0,0, 0,0,1,0,0,0,0};
    tbl[4]  = '{"mul_done",       0,0,0,0,  0,1,42,    0,0,0,    5,0,0,0, 0,0,1,0,1,5,42};
    tbl[5]  = '{"mul_after",      0,0,0,0,  0,0,0,     0,0,0,    5,0,0,0, 0,0,0,0,0,0,0};
    tbl[6]  = '{"div_acc",        0,1,4,3,  0,0,0,     0,0,0,    0,3,0,0, 1,0,1,0,0,0,0};
    tbl[7]  = '{"div_busy",       0,0,0,0,  1,0,0,     0,0,0,    0,3,0,0, 0,0,1,0,0,0,0};
    tbl[8]  = '{"div_done_mem",   0,0,0,0,  0,1,'h11,  1,8,'h88, 0,3,0,0, 0,0,1,0,1,8,'h88};
    tbl[9]  = '{"div_held_wr",    0,0,0,0,  0,0,0,     0,0,0,    0,3,0,0, 0,0,1,0,1,3,'h11};
    tbl[10] = '{"div_after",      0,0,0,0,  0,0,0,     0,0,0,    0,3,0,0, 0,0,0,0,0,0,0};
    tbl[11] = '{"hm_acc",         0,1,0,9,  0,0,0,     0,0,0,    0,0,0,0, 1,0,0,0,0,0,0};
    tbl[12] = '{"second_busy",    0,1,1,10, 1,0,0,     0,0,0,    0,0,0,0, 0,1,0,0,0,0,0};
    tbl[13] = '{"second_done",    0,1,1,10, 0,1,'hAA,  1,1,1,    0,0,0,0, 0,1,0,0,1,1,1};
    tbl[14] = '{"hold1",          0,1,1,10, 0,0,0,     1,2,2,    0,0,0,0, 0,1,0,0,1,2,2};
    tbl[15] = '{"hold2",          0,1,1,10, 0,0,0,     1,3,3,    0,0,0,0, 0,1,0,0,1,3,3};
    tbl[16] = '{"hold3",          0,1,1,10, 0,0,0,     1,4,4,    0,0,0,0, 0,1,0,0,1,4,4};
    tbl[17] = '{"hold_max",       0,1,1,10, 0,0,0,     1,5,5,    0,0,0,0, 0,1,0,1,1,9,'hAA};
    tbl[18] = '{"yield_acc",      0,1,1,10, 0,0,0,     1,5,5,    0,0,0,0, 1,0,0,0,1,5,5};
    tbl[19] = '{"op2_done",       0,0,0,0,  0,1,'h10,  0,0,0,    0,0,0,0, 0,0,0,0,1,10,'h10};
    tbl[20] = '{"op2_after",      0,0,0,0,  0,0,0,     0,0,0,    0,0,0,0, 0,0,0,0,0,0,0};
    tbl[21] = '{"x0_acc",         0,1,0,0,  0,0,0,     0,0,0,    0,0,0,1, 1,0,0,0,0,0,0};
    tbl[22] = '{"x0_busy",        0,0,0,0,  1,0,0,     0,0,0,    0,0,0,1, 0,0,0,0,0,0,0};
    tbl[23] = '{"x0_done",        0,0,0,0,  0,1,'h55,  0,0,0,    0,0,0,1, 0,0,0,0,0,0,0};
    tbl[24] = '{"x7_acc",         0,1,0,7,  0,0,0,     0,0,0,    1,2,7,1, 1,0,1,0,0,0,0};
    tbl[25] = '{"x7_nowb",        0,0,0,0,  1,0,0,     0,0,0,    1,2,7,0, 0,0,0,0,0,0,0};
    tbl[26] = '{"x7_waw",         0,0,0,0,  1,0,0,     0,0,0,    1,2,7,1, 0,0,1,0,0,0,0};
    tbl[27] = '{"rst_mid",        1,0,0,0,  1,0,0,     0,0,0,    7,0,7,1, 0,0,0,0,0,0,0};
    tbl[28] = '{"late_done",      0,0,0,0,  0,1,'h77,  0,0,0,    7,0,7,1, 0,0,0,0,0,0,0};
    tbl[29] = '{"acc_after_rst",  0,1,0,2,  0,0,0,     0,0,0,    0,0,0,0, 1,0,0,0,0,0,0};
    tbl[30] = '{"rst2",           1,0,0,0,  0,0,0,     0,0,0,    0,0,0,0, 0,0,0,0,0,0,0};
    tbl[31] = '{"idle_unit_busy", 0,1,0,6,  1,0,0,     0,0,0,    0,0,0,0, 0,1,0,0,0,0,0};

    for (int i = 0; i < 32; i++) begin
      reset         = tbl[i].rst[0];
      ex_md_valid   = tbl[i].exv[0];
      ex_md_op      = 3'(tbl[i].exop);
      ex_md_rd      = 5'(tbl[i].exrd);
      ex_md_a       = 32'd6;
      ex_md_b       = 32'd7;
      mif.md_busy   = tbl[i].busy[0];
      mif.md_done   = tbl[i].done[0];
      mif.md_result = 32'(tbl[i].res);
      mem1_wb_valid = tbl[i].memv[0];
      mem1_wb_reg   = 5'(tbl[i].memreg);
      mem1_wb_data  = 32'(tbl[i].memdata);
      de_rs1        = 5'(tbl[i].rs1);
      de_rs2        = 5'(tbl[i].rs2);
      de_rd         = 5'(tbl[i].derd);
      de_wb         = tbl[i].dewb[0];
      @(negedge clk);
      check_outs(tbl[i].name, tbl[i].start, tbl[i].exst, tbl[i].dest, tbl[i].wbst,
                 tbl[i].wbv, tbl[i].wbreg, tbl[i].wbdata);
      if (tbl[i].start != 0) begin
        chk({tbl[i].name, ".md_op"}, int'(mif.md_op), tbl[i].exop);
        chk({tbl[i].name, ".md_a"}, int'(mif.md_a), 6);
        chk({tbl[i].name, ".md_b"}, int'(mif.md_b), 7);
      end
      @(posedge clk);
      #1;
    end

    op_run = 0; held = 0; pend = 0; age = 0; run_left = 0; held_val = '0; hold_ex = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit outstanding, acc, mdw, wst, e_exv;
      int hz, e_dest, e_wbreg;
      logic [31:0] wval, e_wbdata;

      reset = (cyc < 2) || ($urandom_range(0, 199) == 0);
      if (!hold_ex) begin
        ex_md_valid = ($urandom_range(0, 2) == 0);
        ex_md_op    = 3'($urandom_range(0, 7));
        ex_md_rd    = 5'($urandom_range(0, 7));
        ex_md_a     = $urandom;
        ex_md_b     = $urandom;
      end
      mif.md_busy   = (run_left > 1);
      mif.md_done   = (run_left == 1);
      mif.md_result = $urandom;
      mem1_wb_valid = ($urandom_range(0, 3) != 0);
      mem1_wb_reg   = 5'($urandom_range(0, 31));
      mem1_wb_data  = $urandom;
      de_rs1        = 5'($urandom_range(0, 7));
      de_rs2        = 5'($urandom_range(0, 7));
      de_rd         = 5'($urandom_range(0, 7));
      de_wb         = 1'($urandom_range(0, 1));

      outstanding = op_run || held;
      acc    = !reset && ex_md_valid && !outstanding && !mif.md_busy;
      e_exv  = !reset && ex_md_valid && (outstanding || mif.md_busy);
      hz     = reset ? 0 : (acc ? int'(ex_md_rd) : (outstanding ? pend : 0));
      e_dest = (hz != 0) && (int'(de_rs1) == hz || int'(de_rs2) == hz || (de_wb && int'(de_rd) == hz));
      mdw = 0; wst = 0; wval = '0;
      if (!reset && op_run && mif.md_done && pend != 0 && !mem1_wb_valid) begin
        mdw = 1; wval = mif.md_result;
      end
      if (!reset && held) begin
        wval = held_val;
        if (!mem1_wb_valid) mdw = 1;
        else if (age == HOLD_MAX) begin mdw = 1; wst = 1; end
      end
      e_wbreg  = reset ? 0 : (mdw ? pend : int'(mem1_wb_reg));
      e_wbdata = reset ? '0 : (mdw ? wval : mem1_wb_data);

      @(negedge clk);
      check_outs("rand", int'(acc), int'(e_exv), e_dest, int'(wst),
                 int'(!reset && (mdw || mem1_wb_valid)), e_wbreg, int'(e_wbdata));
      if (acc) begin
        chk("rand.md_op", int'(mif.md_op), int'(ex_md_op));
        chk("rand.md_a", int'(mif.md_a), int'(ex_md_a));
        chk("rand.md_b", int'(mif.md_b), int'(ex_md_b));
      end

      if (reset) begin
        op_run = 0; held = 0; pend = 0; run_left = 0;
      end else if (acc) begin
        op_run = 1; pend = int'(ex_md_rd); run_left = $urandom_range(1, 5);
      end else begin
        if (op_run && mif.md_done) begin
          op_run = 0;
          if (pend != 0 && mem1_wb_valid) begin held = 1; held_val = mif.md_result; age = 1; end
        end else if (held) begin
          if (mdw) held = 0;
          else age++;
        end
        if (run_left > 0) run_left--;
      end
      hold_ex = e_exv;
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
